// File: rtl/muladd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiply-add datapath between NUM_REQ requesters.
// Optional per-requester saturating grant counters are built when MULADD_ARB_STATS_EN is defined.
module muladd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pause,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*DATA_W-1:0] req_c,
    output logic [DATA_W-1:0]         mac_a,
    output logic [DATA_W-1:0]         mac_b,
    output logic [DATA_W-1:0]         mac_c,
    input  logic [DATA_W-1:0]         mac_y,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_y,
    output logic                      busy,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [LATENCY-1:0] r_tag_valid;
    logic [IDX_W-1:0]   r_tag_idx [LATENCY];

    logic               w_found;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_xfer;

    // Rotating priority search: first valid requester at or after r_rr_ptr, modulo NUM_REQ.
    always_comb begin : grant_search
        int             v_pos;
        logic [IDX_W-1:0] v_idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found     = 1'b0;
        w_grant_idx = '0;
        v_pos       = 0;
        v_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_pos = int'(r_rr_ptr) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            v_idx = IDX_W'(v_pos);
            if (!w_found && req_valid[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    assign w_xfer = w_found & ~pause & ~reset;

    always_comb begin
        req_ready = '0;
        mac_a     = '0;
        mac_b     = '0;
        mac_c     = '0;
        if (w_xfer) begin
            req_ready[w_grant_idx] = 1'b1;
            mac_a = req_a[int'(w_grant_idx)*DATA_W +: DATA_W];
            mac_b = req_b[int'(w_grant_idx)*DATA_W +: DATA_W];
            mac_c = req_c[int'(w_grant_idx)*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_tag_valid <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            r_tag_valid[0] <= w_xfer;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
            end
        end
    end

    // NOTE: the index payload is not reset; it is only observed when its valid bit is set.
    always_ff @(posedge clock) begin
        r_tag_idx[0] <= w_grant_idx;
        for (int i = 1; i < LATENCY; i++) begin
            r_tag_idx[i] <= r_tag_idx[i-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_tag_valid[LATENCY-1]) begin
            rsp_valid[r_tag_idx[LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_y = mac_y;
    assign busy  = ~reset & ((|req_valid) | (|r_tag_valid));

`ifdef MULADD_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_grant_cnt[w_grant_idx] != '1)) begin
            r_grant_cnt[w_grant_idx] <= r_grant_cnt[w_grant_idx] + 1'b1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_grant_cnt[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_muladd_arbiter.sv
// Self-checking bench for muladd_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_muladd_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                      clock;
    logic                      reset;
    logic                      pause;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*DATA_W-1:0] req_c;
    logic [DATA_W-1:0]         mac_a;
    logic [DATA_W-1:0]         mac_b;
    logic [DATA_W-1:0]         mac_c;
    logic [DATA_W-1:0]         mac_y;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_y;
    logic                      busy;
    logic [NUM_REQ*CNT_W-1:0]  grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    muladd_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .pause(pause),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_y(mac_y),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy), .grant_cnt(grant_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the shared datapath: LATENCY-deep a*b+c pipeline.
    logic [DATA_W-1:0] dp_pipe [LATENCY];
    always @(posedge clock) begin
        dp_pipe[0] <= mac_a * mac_b + mac_c;
        for (int i = 1; i < LATENCY; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign mac_y = dp_pipe[LATENCY-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, queue of outstanding results with due cycle.
    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] y;
    } rsp_t;

    rsp_t m_q[$];
    int   m_ptr = 0;
    int   m_cyc = 0;
    int   m_cnt [NUM_REQ];

    always @(negedge clock) begin : model_compare
        int                g;
        rsp_t              ent;
        logic [NUM_REQ-1:0] e_ready;
        logic [NUM_REQ-1:0] e_rsp;
        logic [DATA_W-1:0] e_a, e_b, e_c, e_y;
        logic [31:0]       e_cnt;
        if (reset) begin
            m_q.delete();
            m_ptr = 0;
            for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
        end
        g = -1;
        e_ready = '0;
        e_a = '0; e_b = '0; e_c = '0;
        if (!reset && !pause) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_a = req_a[g*DATA_W +: DATA_W];
            e_b = req_b[g*DATA_W +: DATA_W];
            e_c = req_c[g*DATA_W +: DATA_W];
        end
        e_rsp = '0;
        e_y   = '0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            e_rsp[m_q[0].idx] = 1'b1;
            e_y = m_q[0].y;
        end

        check("model_ready", 32'(req_ready), 32'(e_ready));
        check("model_mac_a", mac_a, e_a);
        check("model_mac_b", mac_b, e_b);
        check("model_mac_c", mac_c, e_c);
        check("model_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        if (e_rsp != '0) check("model_rsp_y", rsp_y, e_y);
        if (!(reset && (|req_valid)))
            check("model_busy", 32'(busy), 32'((|req_valid) || (m_q.size() > 0)));
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MULADD_ARB_STATS_EN
            e_cnt = 32'(m_cnt[i]);
`else
            e_cnt = 32'd0;
`endif
            check("model_grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), e_cnt);
        end

        if (e_rsp != '0) void'(m_q.pop_front());
        if (g >= 0) begin
            ent.due = m_cyc + LATENCY;
            ent.idx = g;
            ent.y   = e_a * e_b + e_c;
            m_q.push_back(ent);
            m_ptr = (g + 1) % NUM_REQ;
            if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
        req_valid[i] = v;
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_c[i*DATA_W +: DATA_W] = c;
    endtask

    function automatic logic [DATA_W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return DATA_W'($urandom_range(0, 15));
            default: return DATA_W'($urandom);
        endcase
    endfunction

    logic [NUM_REQ-1:0] fired;

    initial begin
        reset = 1'b1; pause = 1'b0;
        req_valid = '1; req_a = '0; req_b = '0; req_c = '0;

        // Reset state, with requests pending to show the grant is suppressed.
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        tick();
        req_valid = '0;
        reset = 1'b0;
        tick();

        // Single requester, continuously valid.
        set_req(0, 1'b1, 3, 4, 5);
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check("single_ready", 32'(req_ready), 32'b001);
            if (n >= LATENCY) begin
                check("single_rsp_valid", 32'(rsp_valid), 32'b001);
                check("single_rsp_y", rsp_y, 32'd17);
            end
            tick();
        end
        set_req(0, 1'b0, 0, 0, 0);
        repeat (LATENCY + 1) tick();

        // Wrap-around arithmetic.
        set_req(0, 1'b1, 32'hFFFF_FFFF, 2, 3);
        @(negedge clock);
        check("wrap_ready", 32'(req_ready), 32'b001);
        tick();
        set_req(0, 1'b0, 0, 0, 0);
        for (int k = 1; k < LATENCY; k++) tick();
        @(negedge clock);
        check("wrap_rsp_valid", 32'(rsp_valid), 32'b001);
        check("wrap_rsp_y", rsp_y, 32'h0000_0001);
        tick();

        // One grant to the last requester brings the pointer back to 0.
        set_req(2, 1'b1, 1, 1, 1);
        @(negedge clock);
        check("align_ready", 32'(req_ready), 32'b100);
        tick();
        set_req(2, 1'b0, 0, 0, 0);
        repeat (LATENCY) tick();

        // Contention between requesters 0 and 1.
        set_req(0, 1'b1, 2, 3, 1);
        set_req(1, 1'b1, 5, 6, 7);
        for (int n = 0; n < 4 + LATENCY; n++) begin
            @(negedge clock);
            if (n < 4) check("cont_grant", 32'(req_ready), (n % 2 == 0) ? 32'b001 : 32'b010);
            if (n >= LATENCY) begin
                check("cont_rsp_valid", 32'(rsp_valid), ((n - LATENCY) % 2 == 0) ? 32'b001 : 32'b010);
                check("cont_rsp_y", rsp_y, ((n - LATENCY) % 2 == 0) ? 32'd7 : 32'd37);
            end
            tick();
            if (n == 3) begin
                set_req(0, 1'b0, 0, 0, 0);
                set_req(1, 1'b0, 0, 0, 0);
            end
        end

        // Pause with one operation in flight and requester 1 waiting.
        set_req(0, 1'b1, 10, 10, 10);
        @(negedge clock);
        check("pause_pre_ready", 32'(req_ready), 32'b001);
        tick();
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b1, 7, 8, 9);
        pause = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("pause_ready", 32'(req_ready), 32'd0);
            if (n == LATENCY - 1) begin
                check("pause_inflight_valid", 32'(rsp_valid), 32'b001);
                check("pause_inflight_y", rsp_y, 32'd110);
            end
            tick();
        end
        pause = 1'b0;
        @(negedge clock);
        check("pause_release_grant", 32'(req_ready), 32'b010);
        tick();
        set_req(1, 1'b0, 0, 0, 0);
        for (int k = 1; k < LATENCY; k++) tick();
        @(negedge clock);
        check("pause_rsp_valid", 32'(rsp_valid), 32'b010);
        check("pause_rsp_y", rsp_y, 32'd65);
        tick();

        // Reset in the cycle after a transfer.
        set_req(1, 1'b1, 4, 4, 4);
        @(negedge clock);
        check("rmf_ready", 32'(req_ready), 32'b010);
        tick();
        set_req(1, 1'b0, 0, 0, 0);
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clock);
            check("rmf_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rmf_busy", 32'(busy), 32'd0);
            tick();
        end
        reset = 1'b0;
        for (int n = 0; n <= LATENCY; n++) begin
            @(negedge clock);
            check("rmf_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_req(0, 1'b1, 1, 2, 3);
        set_req(1, 1'b1, 2, 3, 4);
        set_req(2, 1'b1, 3, 4, 5);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("rmf_grant", 32'(req_ready), 32'b001 << n);
            tick();
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 0, 0, 0);
        repeat (LATENCY + 1) tick();

        // Grant counters: 20 transfers from requester 1 after a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1, 1'b1, 1, 1, 1);
        repeat (20) begin
            @(negedge clock);
            check("stats_grant", 32'(req_ready), 32'b010);
            tick();
        end
        set_req(1, 1'b0, 0, 0, 0);
        @(negedge clock);
`ifdef MULADD_ARB_STATS_EN
        check("stats_cnt1", 32'(grant_cnt[CNT_W +: CNT_W]), 32'd15);
        check("stats_cnt0", 32'(grant_cnt[0 +: CNT_W]), 32'd0);
`else
        check("stats_off", 32'(grant_cnt), 32'd0);
`endif
        tick();

        // Randomized traffic; requesters hold operands stable until their transfer.
        repeat (3000) begin
            @(negedge clock);
            fired = req_valid & req_ready;
            tick();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                req_valid = '0;
            end else begin
                reset = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (fired[i] || !req_valid[i]) begin
                        if ($urandom_range(0, 9) < 6) set_req(i, 1'b1, rnd_op(), rnd_op(), rnd_op());
                        else                          set_req(i, 1'b0, 0, 0, 0);
                    end
                end
            end
            pause = ($urandom_range(0, 7) == 0);
        end

        reset = 1'b0;
        pause = 1'b0;
        req_valid = '0;
        repeat (LATENCY + 2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
